// File: rtl/nios2_mult_pkg.sv
// Shared definitions for the Nios II pipelined multiplier: mode encodings and
// the result latency implied by the output-register option.
package nios2_mult_pkg;

  localparam logic [1:0] MODE_MUL    = 2'b00;
  localparam logic [1:0] MODE_MULXUU = 2'b01;
  localparam logic [1:0] MODE_MULXSU = 2'b10;
  localparam logic [1:0] MODE_MULXSS = 2'b11;

  function automatic int unsigned mult_latency(input bit out_reg);
    return out_reg ? 4 : 3;
  endfunction

endpackage

// File: rtl/nios2_mult_pp.sv
// Registered HW x HW unsigned partial product with clock enable; one DSP slice.
module nios2_mult_pp #(
  parameter int HW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [HW-1:0]   a,
  input  logic [HW-1:0]   b,
  output logic [2*HW-1:0] p
);

  logic [2*HW-1:0] p_d, p_q;

  always_comb begin
    p_d = p_q;
    if (en) p_d = {{HW{1'b0}}, a} * {{HW{1'b0}}, b};
  end

  always_ff @(posedge clk) begin
    if (reset) p_q <= '0;
    else       p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/nios2_mult_pipe.sv
// Pipelined MUL/MULXUU/MULXSU/MULXSS unit with valid/ready backpressure, tag
// passthrough and an optional output register.
module nios2_mult_pipe
  import nios2_mult_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 5,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int HW = WIDTH / 2;

  logic stall, en;

  logic                      vld_p0_d, vld_p0_q, vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
  logic signed [WIDTH-1:0]   a_p0_d, a_p0_q, b_p0_d, b_p0_q;
  logic [1:0]                mode_p0_d, mode_p0_q, mode_p1_d, mode_p1_q;
  logic [TAG_W-1:0]          tag_p0_d, tag_p0_q, tag_p1_d, tag_p1_q, tag_p2_d, tag_p2_q;
  logic [WIDTH-1:0]          ca_p1_d, ca_p1_q, cb_p1_d, cb_p1_q;
  logic [WIDTH-1:0]          ll_p1, lh_p1, hl_p1, hh_p1;
  logic [2*WIDTH-1:0]        prod;
  logic [WIDTH-1:0]          hi;
  logic [WIDTH-1:0]          res_p2_d, res_p2_q;

  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = en;

  nios2_mult_pp #(.HW(HW)) u_pp_ll (.clk(clk), .reset(reset), .en(en),
    .a(a_p0_q[HW-1:0]), .b(b_p0_q[HW-1:0]), .p(ll_p1));
  nios2_mult_pp #(.HW(HW)) u_pp_lh (.clk(clk), .reset(reset), .en(en),
    .a(a_p0_q[HW-1:0]), .b(b_p0_q[WIDTH-1:HW]), .p(lh_p1));
  nios2_mult_pp #(.HW(HW)) u_pp_hl (.clk(clk), .reset(reset), .en(en),
    .a(a_p0_q[WIDTH-1:HW]), .b(b_p0_q[HW-1:0]), .p(hl_p1));
  nios2_mult_pp #(.HW(HW)) u_pp_hh (.clk(clk), .reset(reset), .en(en),
    .a(a_p0_q[WIDTH-1:HW]), .b(b_p0_q[WIDTH-1:HW]), .p(hh_p1));

  always_comb begin
    // S1: operand capture
    vld_p0_d  = en ? in_valid : vld_p0_q;
    a_p0_d    = en ? in_a     : a_p0_q;
    b_p0_d    = en ? in_b     : b_p0_q;
    mode_p0_d = en ? in_mode  : mode_p0_q;
    tag_p0_d  = en ? in_tag   : tag_p0_q;

    // S2: sign corrections alongside the partial products
    vld_p1_d  = en ? vld_p0_q  : vld_p1_q;
    mode_p1_d = en ? mode_p0_q : mode_p1_q;
    tag_p1_d  = en ? tag_p0_q  : tag_p1_q;
    ca_p1_d   = ca_p1_q;
    cb_p1_d   = cb_p1_q;
    if (en) begin
      ca_p1_d = (mode_p0_q[1] && a_p0_q[WIDTH-1]) ? b_p0_q : '0;
      cb_p1_d = (mode_p0_q == MODE_MULXSS && b_p0_q[WIDTH-1]) ? a_p0_q : '0;
    end

    // S3: weighted sum, high-word sign correction, word select
    prod = {{WIDTH{1'b0}}, ll_p1}
         + ({{WIDTH{1'b0}}, lh_p1} << HW)
         + ({{WIDTH{1'b0}}, hl_p1} << HW)
         + {hh_p1, {WIDTH{1'b0}}};
    hi   = prod[2*WIDTH-1:WIDTH] - ca_p1_q - cb_p1_q;
    vld_p2_d = en ? vld_p1_q : vld_p2_q;
    tag_p2_d = en ? tag_p1_q : tag_p2_q;
    res_p2_d = res_p2_q;
    if (en) res_p2_d = (mode_p1_q == MODE_MUL) ? prod[WIDTH-1:0] : hi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      a_p0_q    <= '0;
      b_p0_q    <= '0;
      mode_p0_q <= '0;
      mode_p1_q <= '0;
      tag_p0_q  <= '0;
      tag_p1_q  <= '0;
      tag_p2_q  <= '0;
      ca_p1_q   <= '0;
      cb_p1_q   <= '0;
      res_p2_q  <= '0;
    end else begin
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      a_p0_q    <= a_p0_d;
      b_p0_q    <= b_p0_d;
      mode_p0_q <= mode_p0_d;
      mode_p1_q <= mode_p1_d;
      tag_p0_q  <= tag_p0_d;
      tag_p1_q  <= tag_p1_d;
      tag_p2_q  <= tag_p2_d;
      ca_p1_q   <= ca_p1_d;
      cb_p1_q   <= cb_p1_d;
      res_p2_q  <= res_p2_d;
    end
  end

  // S4 (optional): output register
  if (OUT_REG != 0) begin : g_oreg
    logic             vld_p3_d, vld_p3_q;
    logic [WIDTH-1:0] res_p3_d, res_p3_q;
    logic [TAG_W-1:0] tag_p3_d, tag_p3_q;

    always_comb begin
      vld_p3_d = en ? vld_p2_q : vld_p3_q;
      res_p3_d = en ? res_p2_q : res_p3_q;
      tag_p3_d = en ? tag_p2_q : tag_p3_q;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p3_q <= 1'b0;
        res_p3_q <= '0;
        tag_p3_q <= '0;
      end else begin
        vld_p3_q <= vld_p3_d;
        res_p3_q <= res_p3_d;
        tag_p3_q <= tag_p3_d;
      end
    end

    assign out_valid  = vld_p3_q;
    assign out_result = res_p3_q;
    assign out_tag    = tag_p3_q;
    assign busy       = vld_p0_q | vld_p1_q | vld_p2_q | vld_p3_q;
  end else begin : g_noreg
    assign out_valid  = vld_p2_q;
    assign out_result = res_p2_q;
    assign out_tag    = tag_p2_q;
    assign busy       = vld_p0_q | vld_p1_q | vld_p2_q;
  end

endmodule

// File: tb/tb_nios2_mult_pipe.sv
// Scoreboard bench for nios2_mult_pipe: a 32-bit instance with output register
// and a 16-bit instance without, sharing clock and reset.
module tb_nios2_mult_pipe;
  import nios2_mult_pkg::*;

  localparam int LAT32 = mult_latency(1'b1);
  localparam int LAT16 = mult_latency(1'b0);

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  logic clk, reset;
  int   cyc, n_tests, n_fail;
  exp_t q32[$];
  exp_t q16[$];

  logic        iv32, ir32, ov32, or32, busy32;
  logic [31:0] a32, b32, res32;
  logic [1:0]  m32;
  logic [4:0]  t32, ot32;

  logic        iv16, ir16, ov16, or16, busy16;
  logic [15:0] a16, b16, res16;
  logic [1:0]  m16;
  logic [4:0]  t16, ot16;

  nios2_mult_pipe #(.WIDTH(32), .TAG_W(5), .OUT_REG(1)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .in_a(a32), .in_b(b32),
    .in_mode(m32), .in_tag(t32), .out_valid(ov32), .out_ready(or32), .out_result(res32),
    .out_tag(ot32), .busy(busy32));

  nios2_mult_pipe #(.WIDTH(16), .TAG_W(5), .OUT_REG(0)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_mode(m16), .in_tag(t16), .out_valid(ov16), .out_ready(or16), .out_result(res16),
    .out_tag(ot16), .busy(busy16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] m);
    logic [63:0] ea, eb, p;
    ea = {{32{m[1] & a[31]}}, a};
    eb = {{32{(m == 2'b11) & b[31]}}, b};
    p  = ea * eb;
    return (m == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Monitors: pop and compare on every output transfer; also watch stalls.
  logic        hv32, hv16;
  logic [31:0] hr32;
  logic [15:0] hr16;
  logic [4:0]  ht32, ht16;

  always @(negedge clk) begin : mon32
    exp_t e;
    if (reset) hv32 = 1'b0;
    else begin
      if (hv32) begin
        chk("hold_valid32", ov32, 1);
        chk("hold_result32", res32, hr32);
        chk("hold_tag32", ot32, ht32);
      end
      if (ov32 && !or32) chk("stall_in_ready32", ir32, 0);
      if (ov32 && or32) begin
        if (q32.size() == 0) chk("unexpected_out32", res32, 64'hDEAD);
        else begin
          e = q32.pop_front();
          chk("result32", res32, e.res);
          chk("tag32", ot32, e.tag);
          if (e.chk_lat) chk("latency32", cyc - e.cyc, LAT32);
        end
      end
      hv32 = ov32 && !or32;
      hr32 = res32;
      ht32 = ot32;
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (reset) hv16 = 1'b0;
    else begin
      if (hv16) begin
        chk("hold_result16", res16, hr16);
        chk("hold_tag16", ot16, ht16);
      end
      if (ov16 && or16) begin
        if (q16.size() == 0) chk("unexpected_out16", res16, 64'hDEAD);
        else begin
          e = q16.pop_front();
          chk("result16", res16, e.res);
          chk("tag16", ot16, e.tag);
          if (e.chk_lat) chk("latency16", cyc - e.cyc, LAT16);
        end
      end
      hv16 = ov16 && !or16;
      hr16 = res16;
      ht16 = ot16;
    end
  end

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                         input logic [4:0] t, input logic [31:0] exp, input bit lat);
    exp_t e;
    iv32 = 1'b1; a32 = a; b32 = b; m32 = m; t32 = t;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ir32) begin
        e.res = exp; e.tag = t; e.cyc = cyc; e.chk_lat = lat;
        q32.push_back(e);
        @(posedge clk); #1;
        iv32 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    iv32 = 1'b0;
    chk("issue_timeout32", 0, 1);
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                         input logic [4:0] t, input logic [15:0] exp);
    exp_t e;
    iv16 = 1'b1; a16 = a; b16 = b; m16 = m; t16 = t;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ir16) begin
        e.res = {16'h0, exp}; e.tag = t; e.cyc = cyc; e.chk_lat = 1'b1;
        q16.push_back(e);
        @(posedge clk); #1;
        iv16 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    iv16 = 1'b0;
    chk("issue_timeout16", 0, 1);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60; k++) begin
      if (q32.size() == 0 && q16.size() == 0 && !ov32 && !ov16) break;
      @(posedge clk); #1;
    end
    chk(name, q32.size() + q16.size(), 0);
  endtask

  logic [31:0] va [8] = '{32'h0000_0007, 32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0001,
                          32'hFFFF_FFFE, 32'h0001_0000, 32'h7FFF_FFFF, 32'hCAFE_F00D};
  logic [31:0] vb [8] = '{32'h0000_0009, 32'h9ABC_DEF0, 32'h0000_0010, 32'hFFFF_FFFF,
                          32'h7FFF_FFFF, 32'h0001_0000, 32'h8000_0000, 32'h1357_9BDF};

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1;
    iv32 = 0; a32 = 0; b32 = 0; m32 = 0; t32 = 0; or32 = 1;
    iv16 = 0; a16 = 0; b16 = 0; m16 = 0; t16 = 0; or16 = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_out_valid32", ov32, 0);
    chk("rst_out_result32", res32, 0);
    chk("rst_out_tag32", ot32, 0);
    chk("rst_busy32", busy32, 0);
    chk("rst_in_ready32", ir32, 1);
    chk("rst_out_valid16", ov16, 0);
    chk("rst_busy16", busy16, 0);
    @(posedge clk); #1;

    // All-ones operands, one op per mode, back-to-back.
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, MODE_MUL,    5'd1, 32'h0000_0001, 1);
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, MODE_MULXUU, 5'd2, 32'hFFFF_FFFE, 1);
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, MODE_MULXSU, 5'd3, 32'hFFFF_FFFF, 1);
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, MODE_MULXSS, 5'd4, 32'h0000_0000, 1);
    drain("drain_ones");

    // Most-negative operands.
    issue32(32'h8000_0000, 32'h8000_0000, MODE_MULXUU, 5'd5, 32'h4000_0000, 1);
    issue32(32'h8000_0000, 32'h8000_0000, MODE_MULXSS, 5'd6, 32'h4000_0000, 1);
    issue32(32'h8000_0000, 32'h8000_0000, MODE_MULXSU, 5'd7, 32'hC000_0000, 1);
    issue32(32'h8000_0000, 32'h8000_0000, MODE_MUL,    5'd8, 32'h0000_0000, 1);
    drain("drain_minneg");

    // Eight back-to-back mixed ops against the 64-bit reference.
    for (int i = 0; i < 8; i++)
      issue32(va[i], vb[i], 2'(i), 5'(10 + i), ref32(va[i], vb[i], 2'(i)), 1);
    drain("drain_b2b");

    // Backpressure: four ops issued with the consumer stalled.
    or32 = 1'b0;
    for (int i = 0; i < 4; i++)
      issue32(va[i], vb[7 - i], 2'(3 - i), 5'(20 + i), ref32(va[i], vb[7 - i], 2'(3 - i)), 0);
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_busy32", busy32, 1);
    chk("stall_queue32", q32.size(), 4);
    @(posedge clk); #1;
    or32 = 1'b1;
    drain("drain_stall");

    // Reset with three ops in flight discards them.
    issue32(32'h0000_0003, 32'h0000_0005, MODE_MUL, 5'd28, 32'h0000_000F, 1);
    issue32(32'h0000_0004, 32'h0000_0005, MODE_MUL, 5'd29, 32'h0000_0014, 1);
    issue32(32'h0000_0006, 32'h0000_0005, MODE_MUL, 5'd30, 32'h0000_001E, 1);
    reset = 1'b1;
    q32.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid32", ov32, 0);
    chk("midrst_busy32", busy32, 0);
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;
    issue32(32'h0001_0001, 32'h0000_FFFF, MODE_MULXUU, 5'd31, 32'h0000_0000, 1);
    issue32(32'h0001_0001, 32'h0000_FFFF, MODE_MUL,    5'd0,  32'hFFFF_FFFF, 1);
    drain("drain_after_rst");

    // 16-bit, no output register.
    issue16(16'h8000, 16'h0003, MODE_MULXSS, 5'd1, 16'hFFFE);
    issue16(16'h8000, 16'h0003, MODE_MUL,    5'd2, 16'h8000);
    issue16(16'h8000, 16'h0003, MODE_MULXUU, 5'd3, 16'h0001);
    drain("drain_w16");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2_mult_pipe.md
Name: nios2_mult_pipe

Overview:
- Parametrised, pipelined integer multiplier for the Nios II custom datapath. Successor to the fixed 32-bit low-word multiply cell.
- Supports the full MUL / MULXSS / MULXSU / MULXUU set: low word, or high word with selectable operand signedness.
- Adds a valid/ready handshake with backpressure, a tag passthrough for destination-register tracking, and an optional output register.
- Sits between the M-stage operand latch and the writeback mux.

Parameters:
- WIDTH, 32: operand and result width. Must be even and >= 8. Split into two halves of HW = WIDTH/2.
- TAG_W, 5: width of the sideband tag carried with each operation.
- OUT_REG, 1: 1 adds an output register stage (latency 4); 0 gives latency 3.

Ports:
- clk  in  1: clock, rising edge.
- reset  in  1: synchronous, active-high reset.
- in_valid  in  1: operation present on the input bus.
- in_ready  out  1: block accepts an operation this cycle.
- in_a  in  WIDTH: multiplicand (src1).
- in_b  in  WIDTH: multiplier (src2).
- in_mode  in  2: 00 MUL (low word), 01 MULXUU, 10 MULXSU (a signed, b unsigned), 11 MULXSS (high word).
- in_tag  in  TAG_W: sideband tag, returned unchanged with the result.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts the result.
- out_result  out  WIDTH: selected result word.
- out_tag  out  TAG_W: tag of the result.
- busy  out  1: any pipeline stage holds a valid operation.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: all stage valid bits cleared. out_valid=0, out_result=0, out_tag=0, busy=0. in_ready=1 in the cycle after reset deasserts. Data registers are also cleared to 0.
- Reset asserted mid-operation: all in-flight operations are discarded and no out_valid is produced for them. Reset has priority over every other event.
- Transfer rules: input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall.
- While stalled, every stage register, including valid bits, holds its value. out_result and out_tag stay stable while out_valid=1 and out_ready=0.
- Bubbles: when not stalled, the pipeline advances every cycle and bubbles propagate with valid=0. Back-to-back issue gives 1 result per cycle.
- Stage S1 registers a, b, mode, tag and valid.
- Stage S2 registers the four unsigned HW x HW partial products: ll=aL*bL, lh=aL*bH, hl=aH*bL, hh=aH*bH, each 2*HW bits wide. It also registers the sign-correction terms:
  - ca = b if (a signed-mode && a[MSB]) else 0
  - cb = a if (b signed-mode && b[MSB]) else 0
  - a is treated as signed for modes 10 and 11; b only for mode 11.
- Stage S3 sums the partial products, each shifted by its weight, into a 2*WIDTH-bit unsigned product P. The high half is corrected: H = P[2W-1:W] - ca - cb, modulo 2^WIDTH. The result is P[W-1:0] for mode 00, otherwise H.
- With OUT_REG=1, an extra register follows S3.
- Latency: input transfer at cycle t gives out_valid at t+3 (OUT_REG=0) or t+4 (OUT_REG=1), absent stalls.
- All arithmetic is modulo 2^WIDTH. No overflow flag. Mode 00 result is independent of signedness.
- busy = OR of all stage valid bits.

Decomposition:
- Shared package nios2_mult_pkg holds:
  - mode encoding constants MODE_MUL=2'b00, MODE_MULXUU=2'b01, MODE_MULXSU=2'b10, MODE_MULXSS=2'b11
  - a function returning latency from OUT_REG.
- One sub-module, nios2_mult_pp: registered HW x HW unsigned partial-product unit with an enable input, instantiated four times in S2. It maps to DSP blocks.

Test Plan:
- WIDTH=32, OUT_REG=1, a=b=0xFFFFFFFF, one op per mode -> MUL 0x00000001; MULXUU 0xFFFFFFFE; MULXSU 0xFFFFFFFF; MULXSS 0x00000000. Each at exactly 4 cycles after transfer, tags echoed.
- a=b=0x80000000 -> MULXUU 0x40000000, MULXSS 0x40000000, MULXSU 0xC0000000, MUL 0x00000000.
- Back-to-back 8 random ops with out_ready=1 -> 8 consecutive out_valid cycles, in order, matching a 64-bit reference model.
- Hold out_ready=0 for 5 cycles with 4 ops issued -> in_ready=0 after the first result appears, out_result stable, no loss or duplication. Release -> results drain in issue order.
- Assert reset for 1 cycle with 3 ops in flight -> out_valid=0 and busy=0 from the next cycle, no stale result emitted. A new op issued after reset returns correctly.
- WIDTH=16, OUT_REG=0, a=0x8000, b=0x0003 -> MULXSS 0xFFFE, MUL 0x8000, MULXUU 0x0001, each 3 cycles after transfer.
